// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bus bundle used on both sides of the SDRAM port arbiter.
// The requester drives the command fields; the responder drives waitrequest and read data.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM controller: port 0 has fixed priority,
// port 1 is protected by a starvation counter, and read beats are routed back via a tag FIFO.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    sdram_port_arbiter_if.slave    m0,
    sdram_port_arbiter_if.slave    m1,
    sdram_port_arbiter_if.master   s,
    output logic                   rsp_error
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_PENDING);
    localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [MAX_PENDING-1:0] tag_q, tag_d;
    logic [ST_W-1:0]    starve_q, starve_d;
    logic               rsp_error_q, rsp_error_d;

    logic [1:0] port_rd;
    logic [1:0] port_wr;
    logic [1:0] port_req;
    logic [1:0] port_elig;
    logic       rd_slot_free;

    logic       grant_valid;
    logic       grant_id;
    logic       cmd_rd;
    logic       cmd_wr;
    logic       accept;
    logic       push;
    logic       pop;
    logic       tag_out;

    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_writedata;
    logic [BE_W-1:0]   sel_byteenable;

    assign port_rd      = {m1.read,  m0.read};
    assign port_wr      = {m1.write, m0.write};
    assign rd_slot_free = (count_q < FULL_CNT);

    // A read only competes while the registered pending count leaves room for its tag.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign port_req[gi]  = port_rd[gi] | port_wr[gi];
        assign port_elig[gi] = port_wr[gi] | (port_rd[gi] & rd_slot_free);
    end

    // Arbitration and next-state logic.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        state_d     = IDLE;

        case (state_q)
            IDLE: begin
                if (port_elig[1] && (starve_q == STARVE_MAX)) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end else if (port_elig[0]) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (port_elig[1]) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
            end
            HOLD0: begin
                grant_valid = port_req[0];
                grant_id    = 1'b0;
            end
            HOLD1: begin
                grant_valid = port_req[1];
                grant_id    = 1'b1;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = 1'b0;
            end
        endcase

        cmd_rd = grant_valid & port_rd[grant_id];
        cmd_wr = grant_valid & port_wr[grant_id];
        accept = (cmd_rd | cmd_wr) & ~s.waitrequest;

        // A dropped request in HOLDn clears grant_valid, which lands us back in IDLE.
        if (grant_valid && !accept) begin
            state_d = grant_id ? HOLD1 : HOLD0;
        end
    end

    always_comb begin
        sel_address    = grant_id ? m1.address    : m0.address;
        sel_writedata  = grant_id ? m1.writedata  : m0.writedata;
        sel_byteenable = grant_id ? m1.byteenable : m0.byteenable;
    end

    // Command and response outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        s.read       = reset_reset_n & cmd_rd;
        s.write      = reset_reset_n & cmd_wr;
        s.address    = grant_valid ? sel_address    : '0;
        s.writedata  = grant_valid ? sel_writedata  : '0;
        s.byteenable = grant_valid ? sel_byteenable : '0;

        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        if (reset_reset_n && grant_valid) begin
            if (grant_id) begin
                m1.waitrequest = s.waitrequest;
            end else begin
                m0.waitrequest = s.waitrequest;
            end
        end

        pop     = s.readdatavalid & (count_q != '0);
        tag_out = tag_q[rd_ptr_q];

        m0.readdatavalid = reset_reset_n & pop & ~tag_out;
        m1.readdatavalid = reset_reset_n & pop &  tag_out;
        m0.readdata      = s.readdata;
        m1.readdata      = s.readdata;
    end

    // Tag FIFO, starvation counter and error flag.
    always_comb begin
        push = accept & cmd_rd;

        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            tag_d[wr_ptr_q] = grant_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        rsp_error_d = rsp_error_q | (s.readdatavalid & (count_q == '0));

        starve_d = starve_q;
        if (accept && grant_id) begin
            starve_d = '0;
        end else if (port_elig[1] && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_q       <= '0;
            starve_q    <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_q       <= tag_d;
            starve_q    <= starve_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a vector table for single-cycle arbitration
// plus hand sequences; read beats are checked against a scoreboard of expected routings.
module tb_sdram_port_arbiter;

    localparam logic [23:0] A0  = 24'h000100;
    localparam logic [23:0] A1  = 24'h0A0B0C;
    localparam logic [15:0] WD0 = 16'h1111;
    localparam logic [15:0] WD1 = 16'h2222;
    localparam logic [1:0]  BE0 = 2'b11;
    localparam logic [1:0]  BE1 = 2'b01;

    logic clk;
    logic rst_n;
    logic rsp_error;

    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) m0_if ();
    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) m1_if ();
    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) s_if ();

    sdram_port_arbiter #(
        .ADDR_W(24), .DATA_W(16), .MAX_PENDING(4), .STARVE_LIMIT(8)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .m0            (m0_if),
        .m1            (m1_if),
        .s             (s_if),
        .rsp_error     (rsp_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       port;
        logic [15:0] data;
    } rsp_t;

    typedef struct {
        logic        m0r, m0w, m1r, m1w, sw;
        logic        exp_rd, exp_wr;
        logic [23:0] exp_addr;
        logic [15:0] exp_wd;
        logic [1:0]  exp_be;
        logic        exp_w0, exp_w1;
    } vec_t;

    rsp_t sb_q[$];
    rsp_t cur;
    logic cur_v;
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        s_if.readdatavalid = 1'b0;
    endtask

    task automatic clear_inputs();
        m0_if.read = 1'b0; m0_if.write = 1'b0;
        m1_if.read = 1'b0; m1_if.write = 1'b0;
        m0_if.address = A0; m0_if.writedata = WD0; m0_if.byteenable = BE0;
        m1_if.address = A1; m1_if.writedata = WD1; m1_if.byteenable = BE1;
        s_if.waitrequest = 1'b0; s_if.readdata = 16'h0; s_if.readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic start_beat();
        cur_v = 1'b0;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got empty queue, expected a pending read at %0t", $time);
        end else begin
            cur = sb_q.pop_front();
            cur_v = 1'b1;
            s_if.readdata = cur.data;
            s_if.readdatavalid = 1'b1;
        end
    endtask

    task automatic check_beat();
        if (cur_v) begin
            chk("beat_m0_valid", 32'(m0_if.readdatavalid), 32'(cur.port == 1'b0));
            chk("beat_m1_valid", 32'(m1_if.readdatavalid), 32'(cur.port == 1'b1));
            chk("beat_data", 32'(cur.port ? m1_if.readdata : m0_if.readdata), 32'(cur.data));
        end
    endtask

    task automatic drain();
        cyc();
        clear_inputs();
        while (sb_q.size() > 0) begin
            cyc();
            start_beat();
            #1;
            check_beat();
        end
    endtask

    initial begin
        logic        winner;
        logic        prev_rd;
        int          exp_starve;
        logic [1:0]  order [4];

        // Fields: m0r m0w m1r m1w sw | rd wr addr wd be | w0 w1
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 24'h0, 16'h0, 2'b00, 1'b1,1'b1};
        vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0, A0, WD0, BE0, 1'b0,1'b1};
        vecs[2] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1, A1, WD1, BE1, 1'b1,1'b0};
        vecs[3] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0, A0, WD0, BE0, 1'b0,1'b1};
        vecs[4] = '{1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1, A0, WD0, BE0, 1'b1,1'b1};
        vecs[5] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0, A1, WD1, BE1, 1'b1,1'b1};
        vecs[6] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1, A0, WD0, BE0, 1'b0,1'b1};
        order   = '{2'd0, 2'd1, 2'd1, 2'd0};
        cur_v   = 1'b0;
        cur     = '{1'b0, 16'h0};

        // Reset state: outputs quiet even with a request and a stray beat present.
        rst_n = 1'b0;
        clear_inputs();
        m0_if.read = 1'b1;
        s_if.readdatavalid = 1'b1;
        #5;
        chk("rst_s_read", 32'(s_if.read), 32'd0);
        chk("rst_s_write", 32'(s_if.write), 32'd0);
        chk("rst_m0_wait", 32'(m0_if.waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_if.waitrequest), 32'd1);
        chk("rst_m0_valid", 32'(m0_if.readdatavalid), 32'd0);
        chk("rst_m1_valid", 32'(m1_if.readdatavalid), 32'd0);
        chk("rst_error", 32'(rsp_error), 32'd0);

        // Vector table: first-cycle arbitration out of a freshly reset IDLE.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            cyc();
            m0_if.read = vecs[i].m0r; m0_if.write = vecs[i].m0w;
            m1_if.read = vecs[i].m1r; m1_if.write = vecs[i].m1w;
            s_if.waitrequest = vecs[i].sw;
            #1;
            chk($sformatf("vec%0d_s_read", i), 32'(s_if.read), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_s_write", i), 32'(s_if.write), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_m0_wait", i), 32'(m0_if.waitrequest), 32'(vecs[i].exp_w0));
            chk($sformatf("vec%0d_m1_wait", i), 32'(m1_if.waitrequest), 32'(vecs[i].exp_w1));
            if (vecs[i].exp_rd || vecs[i].exp_wr) begin
                chk($sformatf("vec%0d_addr", i), 32'(s_if.address), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_wdata", i), 32'(s_if.writedata), 32'(vecs[i].exp_wd));
                chk($sformatf("vec%0d_be", i), 32'(s_if.byteenable), 32'(vecs[i].exp_be));
            end
        end

        // Single read, response three cycles after acceptance.
        do_reset();
        cyc();
        m0_if.read = 1'b1;
        #1;
        chk("single_s_read", 32'(s_if.read), 32'd1);
        chk("single_s_addr", 32'(s_if.address), 32'h000100);
        sb_q.push_back('{1'b0, 16'hBEEF});
        cyc(); m0_if.read = 1'b0;
        cyc();
        cyc();
        start_beat();
        #1;
        check_beat();

        // Interleaved routing m0, m1, m1, m0.
        for (int i = 0; i < 4; i++) begin
            cyc();
            clear_inputs();
            if (order[i] == 2'd0) m0_if.read = 1'b1; else m1_if.read = 1'b1;
            #1;
            chk($sformatf("inter%0d_s_read", i), 32'(s_if.read), 32'd1);
            chk($sformatf("inter%0d_addr", i), 32'(s_if.address), 32'(order[i] == 2'd0 ? A0 : A1));
            sb_q.push_back('{order[i] == 2'd1, 16'hC000 + 16'(i)});
        end
        drain();

        // Contention: m0 reads (answered one cycle later) against a held m1 write.
        do_reset();
        exp_starve = 0;
        prev_rd = 1'b0;
        for (int k = 0; k < 18; k++) begin
            cyc();
            m0_if.read = 1'b1;
            m1_if.write = 1'b1;
            if (prev_rd) start_beat(); else cur_v = 1'b0;
            #1;
            winner = (exp_starve == 8);
            chk($sformatf("starve%0d_s_read", k), 32'(s_if.read), 32'(!winner));
            chk($sformatf("starve%0d_s_write", k), 32'(s_if.write), 32'(winner));
            chk($sformatf("starve%0d_m0_wait", k), 32'(m0_if.waitrequest), 32'(winner));
            chk($sformatf("starve%0d_m1_wait", k), 32'(m1_if.waitrequest), 32'(!winner));
            check_beat();
            if (winner) begin
                exp_starve = 0;
                prev_rd = 1'b0;
            end else begin
                sb_q.push_back('{1'b0, 16'hA000 + 16'(k)});
                exp_starve++;
                prev_rd = 1'b1;
            end
        end
        cur_v = 1'b0;
        drain();

        // Full pending: four unanswered reads block the fifth, writes still pass.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_if.read = 1'b1;
            #1;
            chk($sformatf("full%0d_s_read", i), 32'(s_if.read), 32'd1);
            sb_q.push_back('{1'b0, 16'hD000 + 16'(i)});
        end
        cyc();
        m1_if.write = 1'b1;
        #1;
        chk("full_blocked_s_read", 32'(s_if.read), 32'd0);
        chk("full_m1_write", 32'(s_if.write), 32'd1);
        chk("full_m0_wait", 32'(m0_if.waitrequest), 32'd1);
        chk("full_m1_wait", 32'(m1_if.waitrequest), 32'd0);
        cyc();
        m1_if.write = 1'b0;
        #1;
        chk("full_still_blocked", 32'(s_if.read), 32'd0);
        cyc();
        start_beat();
        #1;
        check_beat();
        chk("full_pop_cycle_wait", 32'(m0_if.waitrequest), 32'd1);
        cyc();
        #1;
        chk("full_freed_s_read", 32'(s_if.read), 32'd1);
        chk("full_freed_m0_wait", 32'(m0_if.waitrequest), 32'd0);
        sb_q.push_back('{1'b0, 16'hD004});
        drain();

        // Hold lock on port 1 while port 0 starts requesting.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            m1_if.write = 1'b1;
            s_if.waitrequest = 1'b1;
            if (i >= 1) m0_if.read = 1'b1;
            #1;
            chk($sformatf("hold%0d_s_write", i), 32'(s_if.write), 32'd1);
            chk($sformatf("hold%0d_s_read", i), 32'(s_if.read), 32'd0);
            chk($sformatf("hold%0d_addr", i), 32'(s_if.address), 32'(A1));
            chk($sformatf("hold%0d_wdata", i), 32'(s_if.writedata), 32'(WD1));
            chk($sformatf("hold%0d_m0_wait", i), 32'(m0_if.waitrequest), 32'd1);
        end
        cyc();
        s_if.waitrequest = 1'b0;
        #1;
        chk("hold_accept_write", 32'(s_if.write), 32'd1);
        chk("hold_accept_m1_wait", 32'(m1_if.waitrequest), 32'd0);
        chk("hold_accept_m0_wait", 32'(m0_if.waitrequest), 32'd1);
        cyc();
        m1_if.write = 1'b0;
        #1;
        chk("hold_next_s_read", 32'(s_if.read), 32'd1);
        chk("hold_next_addr", 32'(s_if.address), 32'(A0));
        chk("hold_next_m0_wait", 32'(m0_if.waitrequest), 32'd0);
        sb_q.push_back('{1'b0, 16'h5A5A});
        // Port 0 stalls, then illegally withdraws its read while held.
        cyc();
        s_if.waitrequest = 1'b1;
        #1;
        chk("drop_held_s_read", 32'(s_if.read), 32'd1);
        chk("drop_held_m0_wait", 32'(m0_if.waitrequest), 32'd1);
        cyc();
        m0_if.read = 1'b0;
        #1;
        chk("drop_s_read", 32'(s_if.read), 32'd0);
        chk("drop_s_write", 32'(s_if.write), 32'd0);
        drain();

        // Unexpected beat, then reset in the middle of a hold.
        cyc();
        s_if.readdatavalid = 1'b1;
        s_if.readdata = 16'hDEAD;
        #1;
        chk("unexp_m0_valid", 32'(m0_if.readdatavalid), 32'd0);
        chk("unexp_m1_valid", 32'(m1_if.readdatavalid), 32'd0);
        cyc();
        #1;
        chk("unexp_error", 32'(rsp_error), 32'd1);
        cyc();
        m1_if.write = 1'b1;
        s_if.waitrequest = 1'b1;
        #1;
        chk("prehold_s_write", 32'(s_if.write), 32'd1);
        cyc();
        #1;
        chk("inhold_s_write", 32'(s_if.write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_error", 32'(rsp_error), 32'd0);
        chk("midrst_s_write", 32'(s_if.write), 32'd0);
        chk("midrst_s_read", 32'(s_if.read), 32'd0);
        chk("midrst_m0_wait", 32'(m0_if.waitrequest), 32'd1);
        chk("midrst_m1_wait", 32'(m1_if.waitrequest), 32'd1);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
